// File: rtl/phase_2b_rot_sched_pkg.sv
// phase_pkg: shared FSM encoding and rotator limit for phase_2b_rot_sched
package phase_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} phase_sched_state_t;
    localparam int PHASE_KMAX = 3;
endpackage

// File: rtl/phase_2b_rot_sched_if.sv
// phase_2b_rot_sched_if: request/response bundle between requesters and the rotation scheduler
interface phase_2b_rot_sched_if #(parameter int BITSTREAM = 64, parameter int NREQ = 4);
    localparam int ROT_W = $clog2(BITSTREAM);
    localparam int ID_W = $clog2(NREQ);
    logic [NREQ-1:0] in_valid;
    logic [NREQ-1:0] in_ready;
    logic [NREQ*BITSTREAM-1:0] in_bits;
    logic [NREQ*ROT_W-1:0] in_rot;
    logic out_valid;
    logic out_ready;
    logic [BITSTREAM-1:0] out_bits;
    logic [ID_W-1:0] out_id;
    logic busy;
    modport master (output in_valid, in_bits, in_rot, out_ready,
                    input in_ready, out_valid, out_bits, out_id, busy);
    modport slave (input in_valid, in_bits, in_rot, out_ready,
                   output in_ready, out_valid, out_bits, out_id, busy);
endinterface

// File: rtl/phase_2b_rot_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(parameter int N = 4) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    // scan offsets from farthest to nearest so the nearest valid requester wins
    always_comb begin
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) gnt_idx = $clog2(N)'((int'(ptr) + i) % N);
        gnt = (|req) ? N'(1) << gnt_idx : '0;
    end
endmodule

// File: rtl/phase_2b_rot_sched.sv
// phase_2b_rot_sched: round-robin scheduler sharing one PHASE_2b rotator among NREQ requesters
module phase_2b #(parameter int W = 64) (
    input  logic [W-1:0] d_i,
    input  logic [1:0]   k_i,
    output logic [W-1:0] q_o
);
    // single-pass rotate-right by 0..3
    always_comb
        q_o = (k_i == 2'd0) ? d_i :
              (k_i == 2'd1) ? {d_i[0], d_i[W-1:1]} :
              (k_i == 2'd2) ? {d_i[1:0], d_i[W-1:2]} :
                              {d_i[2:0], d_i[W-1:3]};
endmodule

module phase_2b_rot_sched import phase_pkg::*; #(parameter int BITSTREAM = 64, parameter int NREQ = 4) (
    input logic clk,
    input logic rst,
    phase_2b_rot_sched_if.slave bus
);
    localparam int ROT_W = $clog2(BITSTREAM);
    localparam int ID_W = $clog2(NREQ);
    phase_sched_state_t state_q;
    logic [BITSTREAM-1:0] data_q, data_d;
    logic [ROT_W-1:0] rem_q;
    logic [ID_W-1:0] id_q, ptr_q, ptr_d, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [1:0] k;

    rr_arbiter #(.N(NREQ)) u_arb (.req(bus.in_valid), .ptr(ptr_q), .gnt(gnt), .gnt_idx(gnt_idx));
    phase_2b #(.W(BITSTREAM)) u_rot (.d_i(data_q), .k_i(k), .q_o(data_d));

    assign k = (rem_q > ROT_W'(PHASE_KMAX)) ? 2'(PHASE_KMAX) : rem_q[1:0];
    assign ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    assign bus.in_ready = (state_q == IDLE) ? gnt : '0;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_bits = data_q;
    assign bus.out_id = id_q;
    assign bus.busy = state_q != IDLE;

    // accept in IDLE, loop the word through the rotator in BUSY, hold the result in DONE
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            data_q <= '0;
            rem_q <= '0;
            id_q <= '0;
            ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (|bus.in_valid) begin
                    data_q <= bus.in_bits[gnt_idx*BITSTREAM +: BITSTREAM];
                    rem_q <= bus.in_rot[gnt_idx*ROT_W +: ROT_W];
                    id_q <= gnt_idx;
                    ptr_q <= ptr_d;
                    state_q <= BUSY;
                end
                BUSY: begin
                    data_q <= data_d;
                    rem_q <= rem_q - ROT_W'(k);
                    if (rem_q == ROT_W'(k)) state_q <= DONE;
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_phase_2b_rot_sched.sv
// tb_phase_2b_rot_sched: directed and random checks of the rotation scheduler against a protocol-level model
module tb_phase_2b_rot_sched;
    localparam int W = 64, N = 4, RW = 6;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    phase_2b_rot_sched_if #(.BITSTREAM(W), .NREQ(N)) bus();
    phase_2b_rot_sched #(.BITSTREAM(W), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0, checks = 0;
    int mst = 0, mcnt = 0, mptr = 0, mid = 0, maccepts = 0;
    logic [W-1:0] mbits;
    logic [N-1:0] acc_mask = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int r);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) y[i] = x[(i + r) % W];
        return y;
    endfunction

    // model: mst 0 = waiting for a grant, 1 = rotating (mcnt cycles left), 2 = result presented
    always @(negedge clk) begin
        int g, r;
        logic [N-1:0] eg;
        acc_mask = rst ? '0 : (bus.in_valid & bus.in_ready);
        if (rst) begin
            mst = 0;
            mptr = 0;
        end else begin
            chk("busy", bus.busy, mst != 0);
            if (mst == 0) begin
                g = -1;
                for (int i = 0; i < N; i++)
                    if (g < 0 && bus.in_valid[(mptr + i) % N]) g = (mptr + i) % N;
                eg = (g < 0) ? '0 : N'(1) << g;
                chk("in_ready_idle", bus.in_ready, eg);
                chk("out_valid_idle", bus.out_valid, 0);
                if (g >= 0) begin
                    r = int'(bus.in_rot[g*RW +: RW]);
                    mbits = rotr(bus.in_bits[g*W +: W], r);
                    mid = g;
                    mcnt = (r == 0) ? 1 : (r + 2) / 3;
                    mptr = (g + 1) % N;
                    mst = 1;
                    maccepts++;
                end
            end else if (mst == 1) begin
                chk("in_ready_busy", bus.in_ready, 0);
                chk("out_valid_busy", bus.out_valid, 0);
                mcnt--;
                if (mcnt == 0) mst = 2;
            end else begin
                chk("out_valid_done", bus.out_valid, 1);
                chk("out_bits", bus.out_bits, mbits);
                chk("out_id", bus.out_id, mid);
                chk("in_ready_done", bus.in_ready, 0);
                if (bus.out_ready) mst = 0;
            end
        end
    end

    task automatic send(input int id, input logic [W-1:0] x, input int r, output int lat);
        int t;
        @(posedge clk); #1;
        bus.in_valid = '0;
        bus.in_valid[id] = 1'b1;
        bus.in_bits[id*W +: W] = x;
        bus.in_rot[id*RW +: RW] = RW'(r);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.in_ready[id] && t < 200);
        chk("accept_timeout", t < 200, 1);
        @(posedge clk); #1;
        bus.in_valid = '0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            if (bus.out_valid) break;
            lat++;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (mst != 0 && t < 200) begin @(negedge clk); t++; end
        chk("drain_timeout", t < 200, 1);
    endtask

    initial begin
        int lat, gi, t, base;
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] held;
        bus.in_valid = '0;
        bus.in_bits = '0;
        bus.in_rot = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bits", bus.out_bits, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);

        send(0, 64'h1, 1, lat);
        chk("t1_lat", lat, 1);
        chk("t1_bits", bus.out_bits, 64'h8000_0000_0000_0000);
        chk("t1_id", bus.out_id, 0);

        send(2, 64'h0123_4567_89AB_CDEF, 7, lat);
        chk("t2_lat", lat, 3);
        chk("t2_bits", bus.out_bits, 64'hDE02_468A_CF13_579B);
        chk("t2_id", bus.out_id, 2);

        send(1, 64'hA5A5_0F0F_1234_5678, 0, lat);
        chk("t3_rot0_lat", lat, 1);
        chk("t3_rot0_bits", bus.out_bits, 64'hA5A5_0F0F_1234_5678);

        send(3, 64'h1, 63, lat);
        chk("t3_rot63_lat", lat, 21);
        chk("t3_rot63_bits", bus.out_bits, 64'h2);

        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(1, 64'hF000_0000_0000_000F, 5, lat);
        chk("t5_lat", lat, 2);
        held = bus.out_bits;
        chk("t5_bits", held, 64'h7F80_0000_0000_0000);
        repeat (5) begin
            @(negedge clk);
            chk("t5_hold_valid", bus.out_valid, 1);
            chk("t5_hold_bits", bus.out_bits, held);
            chk("t5_hold_id", bus.out_id, 1);
            chk("t5_hold_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_still_valid", bus.out_valid, 1);
        @(negedge clk);
        chk("t5_released_valid", bus.out_valid, 0);
        chk("t5_released_busy", bus.busy, 0);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.in_bits[i*W +: W] = {$urandom, $urandom};
            bus.in_rot[i*RW +: RW] = RW'(1);
        end
        bus.in_valid = '1;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (bus.in_ready == 0 && t < 50);
            chk("t4_timeout", t < 50, 1);
            chk("t4_onehot", $onehot(bus.in_ready), 1);
            gi = -1;
            for (int b = 0; b < N; b++) if (bus.in_ready[b]) gi = b;
            chk("t4_order", gi, exp_ord[n]);
        end
        @(posedge clk); #1 bus.in_valid = '0;
        wait_idle();

        @(posedge clk); #1;
        bus.in_valid = 4'b0010;
        bus.in_rot[1*RW +: RW] = RW'(30);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.in_ready[1] && t < 50);
        chk("t6_accept", t < 50, 1);
        @(posedge clk); #1 bus.in_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = '1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_ptr0", bus.in_ready, 4'b0001);
        @(posedge clk); #1 bus.in_valid = '0;
        wait_idle();

        base = maccepts;
        for (int cyc = 0; cyc < 90000 && maccepts < base + 1000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i] || !bus.in_valid[i]) begin
                    bus.in_valid[i] = ($urandom_range(0, 1) == 1);
                    bus.in_bits[i*W +: W] = {$urandom, $urandom};
                    bus.in_rot[i*RW +: RW] = RW'($urandom_range(0, 63));
                end else if ($urandom_range(0, 9) == 0) begin
                    bus.in_valid[i] = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        chk("random_count", maccepts >= base + 1000, 1);
        @(posedge clk); #1;
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
